// File: rtl/fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// fb_swap_ctrl
// Double-buffered frame store and access scheduler for a 16x32 LED panel.
// Game logic writes whole rows into the back bank while the scan engine reads
// the front bank. A requested swap is held until the scan engine signals a
// frame boundary, so the panel never shows a half-drawn frame. A clear request
// zeroes the back bank over ROWS cycles.
//
// Optional feature (macro FB_COPY_ON_SWAP_EN): after every swap the FSM spends
// ROWS cycles copying the new front bank into the new back bank, so game logic
// can edit the frame incrementally. Without the macro the new back bank keeps
// the stale contents from two frames earlier.
//
// Ports:
//   clk          system clock, all logic on posedge
//   reset_n      asynchronous active-low reset
//   wr_en        write one full row into the back bank
//   wr_row       row index for the write
//   wr_data      row pixels, bit c = column c, 1 = lit
//   clr_req      pulse: zero the entire back bank
//   swap_req     pulse: exchange front/back at the next frame boundary
//   frame_end    pulse from scan engine: last row of the frame latched
//   rd_row       scan engine row address into the front bank
//   rd_data      registered front-bank row (1 cycle latency)
//   front_sel    bank currently displayed (0 = bank A)
//   swap_pending swap requested but not yet executed
//   swap_ack     one-cycle pulse in the cycle after a swap executes
//   busy         clear (or copy) in progress
//   wr_err       pulse, same cycle as the offending request: write/clear rejected
// -----------------------------------------------------------------------------
module fb_swap_ctrl #(
   parameter int ROWS = 16,
   parameter int COLS = 32,
   parameter int RW   = 4
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            wr_en,
   input  logic [RW-1:0]   wr_row,
   input  logic [COLS-1:0] wr_data,
   input  logic            clr_req,
   input  logic            swap_req,
   input  logic            frame_end,
   input  logic [RW-1:0]   rd_row,
   output logic [COLS-1:0] rd_data,
   output logic            front_sel,
   output logic            swap_pending,
   output logic            swap_ack,
   output logic            busy,
   output logic            wr_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1
`ifdef FB_COPY_ON_SWAP_EN
      ,
      S_COPY  = 2'd2
`endif
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [RW-1:0]   r_cnt;
   logic [RW-1:0]   w_cnt_nxt;
   logic            r_front_sel;
   logic            r_swap_pending;
   logic            r_swap_ack;
   logic [COLS-1:0] r_rd_data;

   logic [COLS-1:0] r_mem [2][ROWS];

   logic            w_back_sel;
   logic            w_swap_exec;
   logic            w_clr_ok;
   logic            w_wr_ok;
   logic            w_mem_we;
   logic [RW-1:0]   w_mem_addr;
   logic [COLS-1:0] w_mem_data;
   logic            w_wr_err;

   assign w_back_sel = ~r_front_sel;

   // A swap may only happen while the back bank is quiescent (IDLE); a
   // same-cycle swap_req counts as already pending.
   assign w_swap_exec = (r_state == S_IDLE) && (r_swap_pending || swap_req) && frame_end;

   // The back bank is frozen once a swap is pending. A clear colliding with a
   // swap edge is also refused, since it would otherwise land on whichever
   // bank becomes the back one a cycle later.
   assign w_clr_ok = clr_req && !r_swap_pending && !w_swap_exec;
   // A clear request in the same cycle always wins over a write.
   assign w_wr_ok  = wr_en && !r_swap_pending && !clr_req;

   // ---------------------------------------------------------------------------
   // Next-state, counter and back-bank write port
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_cnt;
      w_mem_data  = '0;
      w_wr_err    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_clr_ok) begin
               w_state_nxt = S_CLEAR;
               w_cnt_nxt   = '0;
            end
`ifdef FB_COPY_ON_SWAP_EN
            if (w_swap_exec) begin
               w_state_nxt = S_COPY;
               w_cnt_nxt   = '0;
            end
`endif
            if (w_wr_ok) begin
               w_mem_we   = 1'b1;
               w_mem_addr = wr_row;
               w_mem_data = wr_data;
            end
            w_wr_err = (wr_en && !w_wr_ok) || (clr_req && !w_clr_ok);
         end

         S_CLEAR: begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt;
            w_mem_data = '0;
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == RW'(ROWS - 1)) w_state_nxt = S_IDLE;
            w_wr_err   = wr_en || clr_req;
         end

`ifdef FB_COPY_ON_SWAP_EN
         S_COPY: begin
            // front_sel already points at the new front, so this copies
            // new_front[i] into new_back[i].
            w_mem_we   = 1'b1;
            w_mem_addr = r_cnt;
            w_mem_data = r_mem[r_front_sel][r_cnt];
            w_cnt_nxt  = r_cnt + 1'b1;
            if (r_cnt == RW'(ROWS - 1)) w_state_nxt = S_IDLE;
            w_wr_err   = wr_en || clr_req;
         end
`endif

         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Control registers and read port
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_front_sel    <= 1'b0;
         r_swap_pending <= 1'b0;
         r_swap_ack     <= 1'b0;
         r_rd_data      <= '0;
      end else begin
         // NOTE: non-blocking assignments make every register see pre-edge
         // values, so the read below returns the old front in a swap cycle.
         r_state        <= w_state_nxt;
         r_cnt          <= w_cnt_nxt;
         r_front_sel    <= r_front_sel ^ w_swap_exec;
         r_swap_pending <= w_swap_exec ? 1'b0 : (r_swap_pending | swap_req);
         r_swap_ack     <= w_swap_exec;
         r_rd_data      <= r_mem[r_front_sel][rd_row];
      end
   end

   // ---------------------------------------------------------------------------
   // Frame storage: two banks, one write port (always the back bank)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the banks are reset explicitly because a blank panel after
         // reset is required behaviour; this forces flops rather than RAM.
         for (int b = 0; b < 2; b++) begin
            for (int r = 0; r < ROWS; r++) begin
               r_mem[b][r] <= '0;
            end
         end
      end else if (w_mem_we) begin
         r_mem[w_back_sel][w_mem_addr] <= w_mem_data;
      end
   end

   assign rd_data      = r_rd_data;
   assign front_sel    = r_front_sel;
   assign swap_pending = r_swap_pending;
   assign swap_ack     = r_swap_ack;
   assign busy         = (r_state != S_IDLE);
   assign wr_err       = w_wr_err;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fb_swap_ctrl
// Directed self-checking bench for fb_swap_ctrl. Inputs change 1 ns after a
// rising edge; registered outputs are sampled there too, and the combinational
// wr_err is sampled 1 ns after its inputs change, well before the next edge.
// Build with +define+FB_COPY_ON_SWAP_EN to exercise the copy-on-swap variant.
// -----------------------------------------------------------------------------
module tb_fb_swap_ctrl;

   localparam int ROWS = 16;
   localparam int COLS = 32;
   localparam int RW   = 4;

   logic            clk;
   logic            reset_n;
   logic            wr_en;
   logic [RW-1:0]   wr_row;
   logic [COLS-1:0] wr_data;
   logic            clr_req;
   logic            swap_req;
   logic            frame_end;
   logic [RW-1:0]   rd_row;
   logic [COLS-1:0] rd_data;
   logic            front_sel;
   logic            swap_pending;
   logic            swap_ack;
   logic            busy;
   logic            wr_err;

   int n_cmp = 0;
   int n_mis = 0;

   fb_swap_ctrl #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .wr_row       (wr_row),
      .wr_data      (wr_data),
      .clr_req      (clr_req),
      .swap_req     (swap_req),
      .frame_end    (frame_end),
      .rd_row       (rd_row),
      .rd_data      (rd_data),
      .front_sel    (front_sel),
      .swap_pending (swap_pending),
      .swap_ack     (swap_ack),
      .busy         (busy),
      .wr_err       (wr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      wr_en     = 1'b0;
      wr_row    = '0;
      wr_data   = '0;
      clr_req   = 1'b0;
      swap_req  = 1'b0;
      frame_end = 1'b0;
   endtask

   // Bounded wait for busy to drop; an expired bound is a mismatch.
   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL %s_wait_idle: busy got %b want 0", tag, busy); end
   endtask

   // Reads every row of the current front bank and expects all zero.
   task automatic read_all_zero(input string tag);
      for (int i = 0; i < ROWS; i++) begin
         rd_row = RW'(i);
         tick();
         n_cmp++; if (rd_data !== '0) begin n_mis++; $display("FAIL %s_row%0d: rd_data got %h want 0", tag, i, rd_data); end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clear_inputs();
      rd_row = '0;
      #3;
      n_cmp++; if (front_sel !== 1'b0)    begin n_mis++; $display("FAIL rst_front_sel: got %b want 0", front_sel); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL rst_swap_pending: got %b want 0", swap_pending); end
      n_cmp++; if (swap_ack !== 1'b0)     begin n_mis++; $display("FAIL rst_swap_ack: got %b want 0", swap_ack); end
      n_cmp++; if (busy !== 1'b0)         begin n_mis++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (wr_err !== 1'b0)       begin n_mis++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
      n_cmp++; if (rd_data !== '0)        begin n_mis++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      tick();
      n_cmp++; if (busy !== 1'b0 || front_sel !== 1'b0) begin n_mis++; $display("FAIL rst_after_release: busy/front_sel got %b/%b want 0/0", busy, front_sel); end
   endtask

   // Plan 1: write row 3, request swap, frame_end five cycles later.
   task automatic test_write_swap();
      wr_en = 1'b1; wr_row = 4'd3; wr_data = 32'h0000_00FF;
      #1;
      n_cmp++; if (wr_err !== 1'b0) begin n_mis++; $display("FAIL t1_wr_err: got %b want 0", wr_err); end
      tick();
      clear_inputs();
      swap_req = 1'b1;
      tick();
      swap_req = 1'b0;
      n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL t1_pending: got %b want 1", swap_pending); end
      n_cmp++; if (front_sel !== 1'b0)    begin n_mis++; $display("FAIL t1_front_early: got %b want 0", front_sel); end
      repeat (4) tick();
      n_cmp++; if (swap_ack !== 1'b0) begin n_mis++; $display("FAIL t1_ack_early: got %b want 0", swap_ack); end
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      n_cmp++; if (front_sel !== 1'b1)    begin n_mis++; $display("FAIL t1_front_sel: got %b want 1", front_sel); end
      n_cmp++; if (swap_ack !== 1'b1)     begin n_mis++; $display("FAIL t1_swap_ack: got %b want 1", swap_ack); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL t1_pending_clr: got %b want 0", swap_pending); end
      tick();
      n_cmp++; if (swap_ack !== 1'b0) begin n_mis++; $display("FAIL t1_ack_pulse: got %b want 0", swap_ack); end
      rd_row = 4'd3;
      tick();
      n_cmp++; if (rd_data !== 32'h0000_00FF) begin n_mis++; $display("FAIL t1_row3: got %h want 000000ff", rd_data); end
      rd_row = 4'd4;
      tick();
      n_cmp++; if (rd_data !== '0) begin n_mis++; $display("FAIL t1_row4: got %h want 0", rd_data); end
      wait_idle("t1");
   endtask

   // Plan 2: write row 0 all-ones, clear, busy for 16 cycles, swap, all zero.
   task automatic test_clear();
      int busy_cycles;
      wr_en = 1'b1; wr_row = 4'd0; wr_data = 32'hFFFF_FFFF;
      tick();
      clear_inputs();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy !== 1'b1) break;
         busy_cycles++;
         tick();
      end
      n_cmp++; if (busy_cycles !== 16) begin n_mis++; $display("FAIL t2_busy_len: got %0d want 16", busy_cycles); end
      swap_req = 1'b1; frame_end = 1'b1;
      tick();
      clear_inputs();
      n_cmp++; if (front_sel !== 1'b0) begin n_mis++; $display("FAIL t2_front_sel: got %b want 0", front_sel); end
      wait_idle("t2");
      read_all_zero("t2");
   endtask

   // Plan 3: swap_req at cycle 0, wr_en at cycle 2, frame_end at cycle 6.
   task automatic test_write_while_pending();
      swap_req = 1'b1;
      tick();                                   // edge 0
      swap_req = 1'b0;
      n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL t3_pending: got %b want 1", swap_pending); end
      tick();                                   // edge 1
      wr_en = 1'b1; wr_row = 4'd7; wr_data = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (wr_err !== 1'b1) begin n_mis++; $display("FAIL t3_wr_err: got %b want 1", wr_err); end
      tick();                                   // edge 2
      clear_inputs();
      #1;
      n_cmp++; if (wr_err !== 1'b0) begin n_mis++; $display("FAIL t3_wr_err_pulse: got %b want 0", wr_err); end
      repeat (3) tick();                        // edges 3..5
      frame_end = 1'b1;
      tick();                                   // edge 6
      frame_end = 1'b0;
      n_cmp++; if (swap_ack !== 1'b1)  begin n_mis++; $display("FAIL t3_swap_ack: got %b want 1", swap_ack); end
      n_cmp++; if (front_sel !== 1'b1) begin n_mis++; $display("FAIL t3_front_sel: got %b want 1", front_sel); end
      wait_idle("t3");
      rd_row = 4'd7;
      tick();
      n_cmp++; if (rd_data !== '0) begin n_mis++; $display("FAIL t3_row7: got %h want 0", rd_data); end
   endtask

   // Plan 4: swap request and frame_end during a clear must wait.
   task automatic test_clear_blocks_swap();
      clr_req = 1'b1;
      tick();                                   // clear cycle 0
      clr_req = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_mis++; $display("FAIL t4_busy: got %b want 1", busy); end
      repeat (3) tick();
      swap_req = 1'b1; frame_end = 1'b1;
      wr_en = 1'b1; wr_row = 4'd1; wr_data = 32'hFFFF_0000;
      #1;
      n_cmp++; if (wr_err !== 1'b1) begin n_mis++; $display("FAIL t4_wr_err: got %b want 1", wr_err); end
      tick();                                   // clear cycle 4
      clear_inputs();
      n_cmp++; if (front_sel !== 1'b1)    begin n_mis++; $display("FAIL t4_no_swap: front_sel got %b want 1", front_sel); end
      n_cmp++; if (swap_pending !== 1'b1) begin n_mis++; $display("FAIL t4_pending: got %b want 1", swap_pending); end
      n_cmp++; if (swap_ack !== 1'b0)     begin n_mis++; $display("FAIL t4_no_ack: got %b want 0", swap_ack); end
      wait_idle("t4");
      tick();
      n_cmp++; if (swap_pending !== 1'b1 || front_sel !== 1'b1) begin n_mis++; $display("FAIL t4_still_pending: pending/front_sel got %b/%b want 1/1", swap_pending, front_sel); end
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      n_cmp++; if (front_sel !== 1'b0)    begin n_mis++; $display("FAIL t4_swap: front_sel got %b want 0", front_sel); end
      n_cmp++; if (swap_ack !== 1'b1)     begin n_mis++; $display("FAIL t4_swap_ack: got %b want 1", swap_ack); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL t4_pending_clr: got %b want 0", swap_pending); end
      wait_idle("t4b");
      rd_row = 4'd1;
      tick();
      n_cmp++; if (rd_data !== '0) begin n_mis++; $display("FAIL t4_row1: got %h want 0", rd_data); end
   endtask

   // Plan 5: swap_req and frame_end together; read in the swap cycle is old.
   task automatic test_same_cycle_swap();
      wr_en = 1'b1; wr_row = 4'd9; wr_data = 32'hA5A5_0F0F;
      tick();
      clear_inputs();
      rd_row = 4'd9; swap_req = 1'b1; frame_end = 1'b1;
      tick();
      clear_inputs();
      n_cmp++; if (rd_data !== '0)     begin n_mis++; $display("FAIL t5_old_front: rd_data got %h want 0", rd_data); end
      n_cmp++; if (front_sel !== 1'b1) begin n_mis++; $display("FAIL t5_front_sel: got %b want 1", front_sel); end
      n_cmp++; if (swap_ack !== 1'b1)  begin n_mis++; $display("FAIL t5_swap_ack: got %b want 1", swap_ack); end
      tick();
      n_cmp++; if (rd_data !== 32'hA5A5_0F0F) begin n_mis++; $display("FAIL t5_new_front: rd_data got %h want a5a50f0f", rd_data); end
      n_cmp++; if (swap_ack !== 1'b0) begin n_mis++; $display("FAIL t5_ack_pulse: got %b want 0", swap_ack); end
      wait_idle("t5");
   endtask

   // Plan 6: reset during clear cycle 7 with a swap pending; then copy check.
   task automatic test_reset_mid_clear();
      int busy_cycles;
      wr_en = 1'b1; wr_row = 4'd2; wr_data = 32'h5555_AAAA;
      tick();
      clear_inputs();
      clr_req = 1'b1;
      tick();                                   // clear cycle 0
      clr_req = 1'b0; swap_req = 1'b1;
      tick();                                   // clear cycle 1
      swap_req = 1'b0;
      repeat (5) tick();                        // into clear cycle 7
      n_cmp++; if (busy !== 1'b1 || swap_pending !== 1'b1) begin n_mis++; $display("FAIL t6_pre: busy/pending got %b/%b want 1/1", busy, swap_pending); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0)         begin n_mis++; $display("FAIL t6_busy: got %b want 0", busy); end
      n_cmp++; if (swap_pending !== 1'b0) begin n_mis++; $display("FAIL t6_pending: got %b want 0", swap_pending); end
      n_cmp++; if (front_sel !== 1'b0)    begin n_mis++; $display("FAIL t6_front_sel: got %b want 0", front_sel); end
      n_cmp++; if (swap_ack !== 1'b0 || wr_err !== 1'b0 || rd_data !== '0) begin n_mis++; $display("FAIL t6_outs: ack/err/rd got %b/%b/%h want 0/0/0", swap_ack, wr_err, rd_data); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      read_all_zero("t6a");
      swap_req = 1'b1; frame_end = 1'b1;
      tick();
      clear_inputs();
      n_cmp++; if (front_sel !== 1'b1) begin n_mis++; $display("FAIL t6_swap: front_sel got %b want 1", front_sel); end
      wait_idle("t6");
      read_all_zero("t6b");

      // Copy-on-swap: row 5 written once must survive two swaps when enabled,
      // and read as stale zero when disabled.
      wr_en = 1'b1; wr_row = 4'd5; wr_data = 32'h1234_5678;
      tick();
      clear_inputs();
      swap_req = 1'b1; frame_end = 1'b1;
      tick();
      clear_inputs();
`ifdef FB_COPY_ON_SWAP_EN
      busy_cycles = 0;
      for (int i = 0; i < 40; i++) begin
         if (busy !== 1'b1) break;
         busy_cycles++;
         tick();
      end
      n_cmp++; if (busy_cycles !== 16) begin n_mis++; $display("FAIL t6_copy_busy: got %0d want 16", busy_cycles); end
`else
      busy_cycles = 0;
      n_cmp++; if (busy !== 1'b0) begin n_mis++; $display("FAIL t6_nocopy_busy: got %b want 0", busy); end
`endif
      swap_req = 1'b1; frame_end = 1'b1;
      tick();
      clear_inputs();
      wait_idle("t6c");
      rd_row = 4'd5;
      tick();
      n_cmp++; if (front_sel !== 1'b1) begin n_mis++; $display("FAIL t6_front2: got %b want 1", front_sel); end
`ifdef FB_COPY_ON_SWAP_EN
      n_cmp++; if (rd_data !== 32'h1234_5678) begin n_mis++; $display("FAIL t6_copy_row5: got %h want 12345678", rd_data); end
`else
      n_cmp++; if (rd_data !== '0) begin n_mis++; $display("FAIL t6_stale_row5: got %h want 0", rd_data); end
`endif
   endtask

   initial begin
      test_reset();
      test_write_swap();
      test_clear();
      test_write_while_pending();
      test_clear_blocks_swap();
      test_same_cycle_swap();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
